bin2bcd_seq: RTL and testbench

Sequential binary-to-packed-BCD converter that feeds the 4-digit multiplexed 7-segment display stage. It takes the unsigned binary ALU result and produces the 16-bit packed BCD word that the display consumes as its result input. Conversion uses iterative double-dabble, one bit per clock, with a start/busy/done handshake. Results above the displayable range saturate and raise a flag.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU result path: converter state encoding,
//   default widths, the largest displayable value and the saturation
//   pattern shown when a result does not fit the display.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGITS_DEF = 4;
    localparam int BIN_W_DEF  = 14;

    // Largest value representable with the given number of decimal digits.
    function automatic int unsigned bcd_max(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam int unsigned BCD_MAX = bcd_max(DIGITS_DEF);

    localparam logic [4*DIGITS_DEF-1:0] BCD_SAT = {DIGITS_DEF{4'h9}};

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
//   Double-dabble correction for one BCD digit: adds 3 when the digit is 5
//   or more, so that the following left shift carries into the next digit.
//   Ports:
//     d  in  4  digit before correction
//     q  out 4  corrected digit
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary to packed-BCD converter (double dabble, one bit per
//   clock) feeding the 7-segment display stage. Values above 10^DIGITS-1
//   saturate to all nines and raise ovf.
//   Handshake: start is sampled only in IDLE; the accepting edge captures
//   bin. busy is high from that edge until the result edge; done pulses
//   for one cycle after the result edge, when bcd/ovf take their new
//   values. busy and done are never high together. start during busy is
//   dropped.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     start, bin  conversion request and operand
//     busy, done  progress / completion pulse
//     bcd, ovf    result registers, held between conversions
//     dbg_state   current FSM state (alu_pkg::state_t encoding)
module bin2bcd_seq
    import alu_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [1:0]            dbg_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [31:0]      MAX_VAL  = 32'(bcd_max(DIGITS));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0] SAT      = {DIGITS{4'h9}};

    state_t               state, state_nxt;
    logic [BIN_W-1:0]     sr;
    logic [BCD_W-1:0]     acc;
    logic [BCD_W-1:0]     acc_adj;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_pend;
    logic                 bin_big;

    assign dbg_state = state;
    assign bin_big   = ({{(32-BIN_W){1'b0}}, bin} > MAX_VAL);

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (acc[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= bin;
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_pend <= bin_big;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    // {acc, sr} shifted left by one after digit correction;
                    // a carry out of the top digit only happens on overflow
                    // and is dropped.
                    acc <= {acc_adj[BCD_W-2:0], sr[BIN_W-1]};
                    sr  <= {sr[BIN_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    bcd  <= ovf_pend ? SAT : acc;
                    ovf  <= ovf_pend;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_pass;

  // scoreboard: {ovf, bcd}
  logic [16:0] exp_q[$];

  bin2bcd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input int b);
    logic [15:0] r;
    if (b > 9999) return {1'b1, 16'h9999};
    r[15:12] = 4'((b / 1000) % 10);
    r[11:8]  = 4'((b / 100) % 10);
    r[7:4]   = 4'((b / 10) % 10);
    r[3:0]   = 4'(b % 10);
    return {1'b0, r};
  endfunction

  // Driver: one conversion with a 1-cycle start. Returns edges from the
  // accepting edge to done (-1 on timeout) and observations taken on the way.
  task automatic do_conv(input int b, input bit scramble, input int poke_at,
                         output int lat, output logic [15:0] obcd,
                         output logic oovf, output bit early_change,
                         output bit busy_bad, output logic busy_at_done);
    logic [15:0] prev;
    prev = bcd;
    lat = -1;
    early_change = 0;
    busy_bad = 0;
    bin = 14'(b);
    start = 1'b1;
    exp_q.push_back(model(b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (bcd !== prev) early_change = 1;
      if (i <= 13 && busy !== 1'b1) busy_bad = 1;
      start = 1'b0;
      if (i == poke_at) begin
        start = 1'b1;
        bin = 14'd5678;
      end
      if (scramble) bin = 14'($urandom_range(0, 16383));
      @(negedge clk);
    end
    obcd = bcd;
    oovf = ovf;
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bin = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, ovf, bcd, dbg_state} !== 21'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b bcd=%h st=%0d, want all 0",
               busy, done, ovf, bcd, dbg_state);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, bcd} !== 18'd0)
      $display("FAIL reset_release_idle: got busy=%b done=%b bcd=%h, want 0", busy, done, bcd);
    else n_pass++;
  endtask

  task automatic check_result(input string name, input int lat, input logic [15:0] obcd,
                              input logic oovf);
    logic [16:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
    n_checks++;
    if (lat !== 15) $display("FAIL %s_latency: got %0d, want 15", name, lat);
    else n_pass++;
    n_checks++;
    if ({oovf, obcd} !== e)
      $display("FAIL %s_result: got ovf=%b bcd=%h, want ovf=%b bcd=%h", name, oovf, obcd, e[16], e[15:0]);
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat; logic [15:0] ob; logic oo; bit ec, bb; logic bd;
    do_conv(1234, 0, -1, lat, ob, oo, ec, bb, bd);
    check_result("basic_1234", lat, ob, oo);
    n_checks++;
    if (bb) $display("FAIL basic_busy: got busy low during shifts, want high");
    else n_pass++;
    n_checks++;
    if (bd !== 1'b0) $display("FAIL basic_busy_at_done: got %b, want 0", bd);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: got done=%b after pulse, want 0", done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int gap;
    logic [16:0] e;
    exp_q.push_back(model(0));
    exp_q.push_back(model(9999));
    bin = 14'd0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bin = 14'd9999;
    for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({ovf, bcd} !== e) $display("FAIL b2b_first: got ovf=%b bcd=%h, want ovf=%b bcd=%h", ovf, bcd, e[16], e[15:0]);
    else n_pass++;
    gap = -1;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done === 1'b1) begin
        gap = i;
        break;
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({ovf, bcd} !== e) $display("FAIL b2b_second: got ovf=%b bcd=%h, want ovf=%b bcd=%h", ovf, bcd, e[16], e[15:0]);
    else n_pass++;
    n_checks++;
    if (gap !== 16) $display("FAIL b2b_gap: got %0d cycles, want 16", gap);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int lat; logic [15:0] ob; logic oo; bit ec, bb; logic bd;
    do_conv(10000, 0, -1, lat, ob, oo, ec, bb, bd);
    check_result("ovf_10000", lat, ob, oo);
    do_conv(16383, 0, -1, lat, ob, oo, ec, bb, bd);
    check_result("ovf_16383", lat, ob, oo);
    do_conv(42, 0, -1, lat, ob, oo, ec, bb, bd);
    check_result("after_ovf_42", lat, ob, oo);
  endtask

  task automatic test_ignore_start();
    int lat; logic [15:0] ob; logic oo; bit ec, bb; logic bd;
    int extra;
    do_conv(1234, 0, 5, lat, ob, oo, ec, bb, bd);
    check_result("ignore_start", lat, ob, oo);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL ignore_extra_done: got %0d extra done pulses, want 0", extra);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int lat; logic [15:0] ob; logic oo; bit ec, bb; logic bd;
    bin = 14'd4321;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, ovf, bcd, dbg_state} !== 21'd0)
      $display("FAIL async_reset: got busy=%b done=%b ovf=%b bcd=%h st=%0d, want all 0",
               busy, done, ovf, bcd, dbg_state);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_conv(7, 0, -1, lat, ob, oo, ec, bb, bd);
    check_result("after_reset_7", lat, ob, oo);
  endtask

  task automatic test_bin_change();
    int lat; logic [15:0] ob; logic oo; bit ec, bb; logic bd;
    do_conv(305, 1, -1, lat, ob, oo, ec, bb, bd);
    check_result("bin_change_305", lat, ob, oo);
    n_checks++;
    if (ec) $display("FAIL bcd_hold: got bcd change before done, want hold");
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_ignore_start();
    test_async_reset();
    test_bin_change();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d left, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
